// File: rtl/uesprit_acc_ctrl.sv
//------------------------------------------------------------------------------
// Module   : uesprit_acc_ctrl
// Brief    : Frame-aligned sequencer and new_acc generator for the U-ESPRIT
//            correlation datapath. Optional macro: UESPRIT_ACC_CTRL_SYNC_CHECK_EN
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uesprit_acc_ctrl #(
  parameter int DIN_WIDTH     = 18,
  parameter int VECTOR_LEN    = 512,
  parameter int ACC_LEN_WIDTH = 16,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DIN_WIDTH-1:0]   din1_re,
  input  logic signed [DIN_WIDTH-1:0]   din1_im,
  input  logic signed [DIN_WIDTH-1:0]   din2_re,
  input  logic signed [DIN_WIDTH-1:0]   din2_im,
  input  logic                          din_valid,
  input  logic                          sync_in,
  input  logic                          arm,
  input  logic [ACC_LEN_WIDTH-1:0]      acc_len,
  output logic signed [DIN_WIDTH-1:0]   dout1_re,
  output logic signed [DIN_WIDTH-1:0]   dout1_im,
  output logic signed [DIN_WIDTH-1:0]   dout2_re,
  output logic signed [DIN_WIDTH-1:0]   dout2_im,
  output logic                          dout_valid,
  output logic                          new_acc,
  output logic [$clog2(VECTOR_LEN)-1:0] chan_idx,
  output logic [ACC_LEN_WIDTH-1:0]      spect_idx,
  output logic [CNT_WIDTH-1:0]          acc_cnt,
  output logic                          running,
  output logic                          sync_err
);

  localparam int                       c_chan_w    = $clog2(VECTOR_LEN);
  localparam logic [c_chan_w-1:0]      c_chan_last = c_chan_w'(VECTOR_LEN - 1);
  localparam logic [c_chan_w-1:0]      c_chan_one  = c_chan_w'(1);
  localparam logic [ACC_LEN_WIDTH-1:0] c_len_one   = ACC_LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]     c_cnt_one   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_SYNC = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  state_t                   r_state;
  logic [c_chan_w-1:0]      r_chan;
  logic [ACC_LEN_WIDTH-1:0] r_spect;
  logic [ACC_LEN_WIDTH-1:0] r_acc_len_q;
  logic                     r_first_win;

  logic                     w_fwd;
  logic                     w_win_start;
  logic                     w_chan_last;
  logic                     w_spect_last;
  logic                     w_misalign;
  logic [ACC_LEN_WIDTH-1:0] w_acc_len_eff;

  // r_chan/r_spect describe the next sample to be forwarded, not the one on dout
  assign w_fwd         = din_valid && (r_state == S_RUN);
  assign w_win_start   = (r_chan == '0) && (r_spect == '0);
  assign w_chan_last   = (r_chan == c_chan_last);
  assign w_spect_last  = (r_spect == (r_acc_len_q - c_len_one));
  assign w_acc_len_eff = (acc_len == '0) ? c_len_one : acc_len;

`ifdef UESPRIT_ACC_CTRL_SYNC_CHECK_EN
  assign w_misalign = (r_state == S_RUN) && sync_in && (r_chan != '0);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_chan      <= '0;
      r_spect     <= '0;
      r_acc_len_q <= c_len_one;
      r_first_win <= 1'b0;
      dout1_re    <= '0;
      dout1_im    <= '0;
      dout2_re    <= '0;
      dout2_im    <= '0;
      dout_valid  <= 1'b0;
      new_acc     <= 1'b0;
      chan_idx    <= '0;
      spect_idx   <= '0;
      acc_cnt     <= '0;
      running     <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      dout1_re   <= din1_re;
      dout1_im   <= din1_im;
      dout2_re   <= din2_re;
      dout2_im   <= din2_im;
      dout_valid <= w_fwd;
      new_acc    <= w_fwd && w_win_start;
      if (w_fwd) begin
        chan_idx  <= r_chan;
        spect_idx <= r_spect;
      end

      if (arm) begin
        r_state     <= S_WAIT_SYNC;
        running     <= 1'b0;
        sync_err    <= 1'b0;
        acc_cnt     <= '0;
        r_chan      <= '0;
        r_spect     <= '0;
        r_first_win <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            running <= 1'b0;
          end
          // A valid arriving with sync belongs to the previous frame and is dropped
          S_WAIT_SYNC: begin
            if (sync_in) begin
              r_state     <= S_RUN;
              running     <= 1'b1;
              r_chan      <= '0;
              r_spect     <= '0;
              r_first_win <= 1'b1;
            end
          end
          S_RUN: begin
            if (w_fwd) begin
              if (w_win_start) begin
                r_acc_len_q <= w_acc_len_eff;
                if (r_first_win) begin
                  r_first_win <= 1'b0;
                end else if (acc_cnt != '1) begin
                  acc_cnt <= acc_cnt + c_cnt_one;
                end
              end
              if (w_chan_last) begin
                r_chan  <= '0;
                r_spect <= w_spect_last ? '0 : (r_spect + c_len_one);
              end else begin
                r_chan <= r_chan + c_chan_one;
              end
            end
            if (w_misalign) begin
              r_state     <= S_WAIT_SYNC;
              running     <= 1'b0;
              sync_err    <= 1'b1;
              r_chan      <= '0;
              r_spect     <= '0;
              r_first_win <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/uesprit_acc_ctrl.md
Name: uesprit_acc_ctrl

Overview:
- Sequencing controller in front of the vector U-ESPRIT correlation datapath.
- Aligns the two-channel complex spectral stream to the FFT frame sync and tracks the channel and spectrum indices.
- Generates new_acc so that each integration window covers exactly acc_len spectra of VECTOR_LEN channels.
- Forwards data and valid one cycle later, registered, so the datapath sees the pulse aligned with channel 0 of the window's first spectrum.

Parameters:
DIN_WIDTH, 18, width of each real/imag input sample
VECTOR_LEN, 512, channels per spectrum (power of two, >=2)
ACC_LEN_WIDTH, 16, width of the acc_len config and spectrum counter
CNT_WIDTH, 32, width of the completed-integration counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
din1_re, din1_im, din2_re, din2_im  in  DIN_WIDTH each  signed antenna 1/2 spectral samples
din_valid  in  1  sample valid
sync_in  in  1  frame sync pulse; next valid sample is channel 0
arm  in  1  single-cycle pulse; (re)starts alignment
acc_len  in  ACC_LEN_WIDTH  spectra per integration; 0 treated as 1
dout1_re, dout1_im, dout2_re, dout2_im  out  DIN_WIDTH each  registered data to datapath
dout_valid  out  1  registered valid to datapath
new_acc  out  1  window-start pulse to datapath, coincident with dout_valid
chan_idx  out  log2(VECTOR_LEN)  channel index of the current dout sample
spect_idx  out  ACC_LEN_WIDTH  spectrum index within the window
acc_cnt  out  CNT_WIDTH  completed integrations since arm
running  out  1  high in RUN state
sync_err  out  1  sticky misalignment flag, cleared by arm

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs and counters 0, including data regs, dout_valid, new_acc and sync_err.
  - acc_len_q = 1.
- States and transitions:
  - IDLE: arm -> WAIT_SYNC.
  - WAIT_SYNC: wait for sync_in -> RUN, with counters cleared and first_win=1. Samples are not forwarded (dout_valid=0).
  - RUN: forward samples. arm -> WAIT_SYNC. Misaligned sync (see optional feature) -> WAIT_SYNC.
  - arm in any state clears sync_err, acc_cnt and the counters, then goes to WAIT_SYNC.
- Data path:
  - Every cycle, dout* <= din*.
  - dout_valid <= din_valid && state==RUN (computed on the input cycle).
  - Latency is 1 cycle; data passes unmodified.
- Counters (advance only on forwarded valid samples):
  - chan wraps at VECTOR_LEN-1 -> 0.
  - On chan wrap, spect increments; it wraps at acc_len_q-1 -> 0.
- new_acc:
  - Asserted with a forwarded sample when chan==0 && spect==0. This covers the first sample after entering RUN and every window boundary.
  - At every window start, acc_len_q <= max(acc_len,1). Mid-window changes of acc_len take effect at the next window.
- acc_cnt:
  - Increments on each new_acc except when first_win=1; first_win then clears.
  - The first new_acc only starts accumulation; there is no prior valid result.
  - acc_cnt saturates at all-ones.
- Indices: chan_idx and spect_idx are registered alongside dout and describe the sample currently on dout.
- Gaps: din_valid may drop for any number of cycles; counters hold.
- Simultaneous events:
  - arm wins over sync_in in the same cycle; the next sync is required.
  - sync_in in the same cycle as din_valid in WAIT_SYNC: that sample is not channel 0 and is dropped.

Optional Feature:
- Macro: UESPRIT_ACC_CTRL_SYNC_CHECK_EN.
- Defined: in RUN, a sync_in while chan!=0 (the next expected sample is not channel 0) sets sync_err and returns to WAIT_SYNC. The partial window is abandoned, and the next window's new_acc has first_win=1, so acc_cnt is not incremented.
- Not defined: sync_in is ignored outside WAIT_SYNC, and sync_err stays 0.

Test Plan (VECTOR_LEN=8, acc_len=3):
- Reset mid-RUN (rst pulsed while streaming) -> next cycle all outputs 0, state IDLE; valids ignored until arm+sync.
- arm, sync, 48 contiguous valids -> dout_valid 48 cycles lagging din by 1; new_acc on samples 0, 24 only; acc_cnt=1 after sample 24.
- Change acc_len 3->2 at sample 10 -> next new_acc still at sample 24, following one at sample 40.
- acc_len=0, 16 valids with random gaps -> new_acc at samples 0 and 8; chan_idx/spect_idx hold across gaps.
- With SYNC_CHECK_EN, sync at chan=5 -> sync_err=1, dout_valid stops until next sync; acc_cnt unchanged. Without the macro -> stream continues and sync_err=0.
- arm and sync_in in same cycle -> stays in WAIT_SYNC; RUN only after the next sync.
